// File: rtl/pulse_seq_pkg.sv
// Shared types and defaults for the pulse sequencer: FSM state encoding,
// table-entry payload and size defaults.
package pulse_seq_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned DEFAULT_CNT_W = 8;
    // Table fields are sized for the widest supported duration counter.
    localparam int unsigned MAX_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_CNT_W-1:0] width;
        logic [MAX_CNT_W-1:0] gap;
    } entry_t;

    function automatic entry_t make_entry(input logic [MAX_CNT_W-1:0] width,
                                          input logic [MAX_CNT_W-1:0] gap);
        entry_t e;
        e.width = width;
        e.gap   = gap;
        return e;
    endfunction

endpackage

// File: rtl/pulse_seq_timer.sv
// Loadable saturating down-counter shared by the HIGH and LOW phases;
// expire is registered and is high while the count sits at zero.
module pulse_seq_timer
    import pulse_seq_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt_c;

    // Next count: clear wins over load, otherwise count down and stick at zero.
    always_comb begin
        cnt_nxt_c = cnt;
        if (clear) begin
            cnt_nxt_c = '0;
        end else if (load) begin
            cnt_nxt_c = load_val;
        end else if (cnt != '0) begin
            cnt_nxt_c = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            expire <= 1'b1;
        end else begin
            cnt    <= cnt_nxt_c;
            expire <= (cnt_nxt_c == '0);
        end
    end

endmodule

// File: rtl/pulse_sequencer.sv
// Table-driven pulse train generator: plays entries 0..seq_last as
// (width+1) high / (gap+1) low runs. Optional PULSE_SEQ_LOOP_EN adds loop_en.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [CNT_W-1:0]         cfg_width,
    input  logic [CNT_W-1:0]         cfg_gap,
    input  logic [$clog2(DEPTH)-1:0] seq_last,
    input  logic                     start,
    input  logic                     abort,
`ifdef PULSE_SEQ_LOOP_EN
    input  logic                     loop_en,
`endif
    output logic                     pulse_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] entry_idx
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t           state;
    entry_t           tbl [DEPTH];
    logic [IDX_W-1:0] last_q;

    logic             tmr_clear_c;
    logic             tmr_load_c;
    logic [CNT_W-1:0] tmr_val_c;
    logic             tmr_expire;

    logic             last_hit_c;
    logic             loop_c;
    entry_t           cur_c;
    entry_t           nxt_c;
    entry_t           first_c;

`ifdef PULSE_SEQ_LOOP_EN
    assign loop_c = loop_en;
`else
    assign loop_c = 1'b0;
`endif

    assign cur_c      = tbl[entry_idx];
    assign nxt_c      = tbl[entry_idx + IDX_W'(1)];
    assign first_c    = tbl[0];
    assign last_hit_c = (entry_idx == last_q);

    // Pulse table; writes only land while the sequencer is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl[IDX_W'(i)] <= '0;
            end
        end else if (cfg_we && (state == ST_IDLE)) begin
            tbl[cfg_addr] <= make_entry(MAX_CNT_W'(cfg_width), MAX_CNT_W'(cfg_gap));
        end
    end

    // Timer control issued on the same edge as the matching state change.
    always_comb begin
        tmr_clear_c = 1'b0;
        tmr_load_c  = 1'b0;
        tmr_val_c   = '0;
        if (abort) begin
            tmr_clear_c = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        tmr_load_c = 1'b1;
                        tmr_val_c  = CNT_W'(first_c.width);
                    end
                end
                ST_HIGH: begin
                    if (tmr_expire) begin
                        tmr_load_c = 1'b1;
                        tmr_val_c  = CNT_W'(cur_c.gap);
                    end
                end
                ST_LOW: begin
                    if (tmr_expire) begin
                        if (!last_hit_c) begin
                            tmr_load_c = 1'b1;
                            tmr_val_c  = CNT_W'(nxt_c.width);
                        end else if (loop_c) begin
                            tmr_load_c = 1'b1;
                            tmr_val_c  = CNT_W'(first_c.width);
                        end else begin
                            tmr_clear_c = 1'b1;
                        end
                    end
                end
                default: tmr_clear_c = 1'b1;
            endcase
        end
    end

    pulse_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear_c),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .expire   (tmr_expire)
    );

    // Sequencer FSM with registered outputs; abort overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            entry_idx <= '0;
            last_q    <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                pulse_out <= 1'b0;
                busy      <= 1'b0;
                entry_idx <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start) begin
                            last_q    <= seq_last;
                            entry_idx <= '0;
                            state     <= ST_HIGH;
                            pulse_out <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (tmr_expire) begin
                            state     <= ST_LOW;
                            pulse_out <= 1'b0;
                        end
                    end
                    ST_LOW: begin
                        if (tmr_expire) begin
                            if (!last_hit_c) begin
                                entry_idx <= entry_idx + IDX_W'(1);
                                state     <= ST_HIGH;
                                pulse_out <= 1'b1;
                            end else if (loop_c) begin
                                entry_idx <= '0;
                                state     <= ST_HIGH;
                                pulse_out <= 1'b1;
                            end else begin
                                entry_idx <= '0;
                                state     <= ST_IDLE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        pulse_out <= 1'b0;
                        busy      <= 1'b0;
                        entry_idx <= '0;
                    end
                endcase
            end
        end
    end

endmodule
